// File: rtl/cart_loader.sv
// cart_loader: parses a 16-byte iNES header into cfg_out and writes the PRG/CHR sections into the cartridge ROM write ports (header magic check built only when CART_LOADER_MAGIC_CHECK_EN is defined).
// Latency: byte accepted at t -> one-cycle write strobe at t+1; header byte 15 accepted at t -> cfg_out/cfg_upd_out at t+1.
// Backpressure: rom_ready_out depends on state only (high in HDR/TRAIN/PRG/CHR); sustains one byte per cycle with back-to-back strobes.
module cart_loader (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic        start_in,
   input  logic [7:0]  rom_d_in,
   input  logic        rom_valid_in,
   output logic        rom_ready_out,
   output logic [39:0] cfg_out,
   output logic        cfg_upd_out,
   output logic        prg_nce_out,
   output logic [14:0] prg_a_out,
   output logic        prg_r_nw_out,
   output logic [7:0]  prg_d_out,
   output logic [13:0] chr_a_out,
   output logic        chr_r_nw_out,
   output logic [7:0]  chr_d_out,
   output logic        busy_out,
   output logic        done_out,
   output logic        err_out
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_HDR   = 3'd1;
   localparam logic [2:0] S_TRAIN = 3'd2;
   localparam logic [2:0] S_PRG   = 3'd3;
   localparam logic [2:0] S_CHR   = 3'd4;
   localparam logic [2:0] S_DONE  = 3'd5;
   localparam logic [2:0] S_ERR   = 3'd6;

   logic [2:0]  r_state;
   logic [14:0] r_cnt;
   logic [39:0] r_shadow;
   logic [39:0] r_cfg;
   logic        r_cfg_upd;
   logic        r_prg_stb;
   logic [14:0] r_prg_a;
   logic [7:0]  r_prg_d;
   logic        r_chr_stb;
   logic [12:0] r_chr_a;
   logic [7:0]  r_chr_d;

   logic        w_busy;
   logic        w_start;
   logic        w_acc;
   logic        w_last;
   logic        w_magic_bad;
   logic        w_hdr_ok;

   assign w_busy  = (r_state == S_HDR) || (r_state == S_TRAIN) ||
                    (r_state == S_PRG) || (r_state == S_CHR);
   assign w_start = start_in && ((r_state == S_IDLE) || (r_state == S_DONE) ||
                                 (r_state == S_ERR));
   assign w_acc   = rom_valid_in && w_busy;

`ifdef CART_LOADER_MAGIC_CHECK_EN
   logic       r_magic_bad;
   logic [7:0] w_magic_exp;

   // Expected "NES\x1A" signature byte for the current header position
   always_comb begin
      w_magic_exp = 8'h00;
      case (r_cnt[1:0])
         2'd0:    w_magic_exp = 8'h4E;
         2'd1:    w_magic_exp = 8'h45;
         2'd2:    w_magic_exp = 8'h53;
         default: w_magic_exp = 8'h1A;
      endcase
   end

   // Sticky signature mismatch flag, judged together with the rest of the header at byte 15
   always_ff @(posedge clk_in) begin
      if (rst_in || w_start) begin
         r_magic_bad <= 1'b0;
      end else if (w_acc && (r_state == S_HDR) && (r_cnt < 15'd4) &&
                   (rom_d_in != w_magic_exp)) begin
         r_magic_bad <= 1'b1;
      end
   end

   assign w_magic_bad = r_magic_bad;
`else
   assign w_magic_bad = 1'b0;
`endif

   // Header acceptance: PRG bank count must be 1 or 2, CHR bank count 0 or 1
   assign w_hdr_ok = ((r_shadow[7:0] == 8'd1) || (r_shadow[7:0] == 8'd2)) &&
                     (r_shadow[15:8] <= 8'd1) && !w_magic_bad;

   // Last byte of the current section; PRG length follows the accepted bank count
   always_comb begin
      w_last = 1'b0;
      case (r_state)
         S_HDR:   w_last = (r_cnt == 15'd15);
         S_TRAIN: w_last = (r_cnt == 15'd511);
         S_PRG:   w_last = (r_cnt == (r_cfg[1] ? 15'h7FFF : 15'h3FFF));
         S_CHR:   w_last = (r_cnt == 15'h1FFF);
         default: w_last = 1'b0;
      endcase
   end

   // Section byte counter, restarted on every section entry
   always_ff @(posedge clk_in) begin
      if (rst_in || w_start) begin
         r_cnt <= 15'd0;
      end else if (w_acc) begin
         r_cnt <= w_last ? 15'd0 : r_cnt + 15'd1;
      end
   end

   // Load sequencing; section changes happen on acceptance of the section's last byte
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state <= S_IDLE;
      end else if (w_start) begin
         r_state <= S_HDR;
      end else if (w_acc && w_last) begin
         case (r_state)
            S_HDR:   r_state <= !w_hdr_ok    ? S_ERR :
                                (r_shadow[18] ? S_TRAIN : S_PRG);
            S_TRAIN: r_state <= S_PRG;
            S_PRG:   r_state <= r_cfg[8] ? S_CHR : S_DONE;
            S_CHR:   r_state <= S_DONE;
            default: r_state <= r_state;
         endcase
      end
   end

   // Header bytes 4..8 go to the shadow; the live config only changes on a good header
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_shadow  <= 40'h0;
         r_cfg     <= 40'h0;
         r_cfg_upd <= 1'b0;
      end else begin
         r_cfg_upd <= 1'b0;
         if (w_acc && (r_state == S_HDR)) begin
            case (r_cnt)
               15'd4:   r_shadow[7:0]   <= rom_d_in;
               15'd5:   r_shadow[15:8]  <= rom_d_in;
               15'd6:   r_shadow[23:16] <= rom_d_in;
               15'd7:   r_shadow[31:24] <= rom_d_in;
               15'd8:   r_shadow[39:32] <= rom_d_in;
               default: r_shadow        <= r_shadow;
            endcase
            if (w_last && w_hdr_ok) begin
               r_cfg     <= r_shadow;
               r_cfg_upd <= 1'b1;
            end
         end
      end
   end

   // Register address/data of each PRG/CHR byte and raise a one-cycle write strobe
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_prg_stb <= 1'b0;
         r_prg_a   <= 15'd0;
         r_prg_d   <= 8'd0;
         r_chr_stb <= 1'b0;
         r_chr_a   <= 13'd0;
         r_chr_d   <= 8'd0;
      end else begin
         r_prg_stb <= 1'b0;
         r_chr_stb <= 1'b0;
         if (w_acc && (r_state == S_PRG)) begin
            r_prg_stb <= 1'b1;
            r_prg_a   <= r_cnt;
            r_prg_d   <= rom_d_in;
         end
         if (w_acc && (r_state == S_CHR)) begin
            r_chr_stb <= 1'b1;
            r_chr_a   <= r_cnt[12:0];
            r_chr_d   <= rom_d_in;
         end
      end
   end

   assign rom_ready_out = w_busy;
   assign busy_out      = w_busy;
   assign done_out      = (r_state == S_DONE);
   assign err_out       = (r_state == S_ERR);
   assign cfg_out       = r_cfg;
   assign cfg_upd_out   = r_cfg_upd;
   assign prg_nce_out   = ~r_prg_stb;
   assign prg_r_nw_out  = ~r_prg_stb;
   assign prg_a_out     = r_prg_a;
   assign prg_d_out     = r_prg_d;
   assign chr_r_nw_out  = ~r_chr_stb;
   assign chr_a_out     = {1'b0, r_chr_a};
   assign chr_d_out     = r_chr_d;

endmodule

// File: tb/tb_cart_loader.sv
// tb_cart_loader: random iNES images streamed into cart_loader, every write strobe scored against the image.
// Expected outcome, config and section lengths come from the header rules applied to the image bytes.
// Signature expectations follow CART_LOADER_MAGIC_CHECK_EN as compiled.
module tb_cart_loader;

   localparam int IMG_MAX = 16 + 512 + 32768 + 8192;

   logic        clk_in = 1'b0;
   logic        rst_in = 1'b1;
   logic        start_in = 1'b0;
   logic [7:0]  rom_d_in = 8'h00;
   logic        rom_valid_in = 1'b0;
   logic        rom_ready_out;
   logic [39:0] cfg_out;
   logic        cfg_upd_out;
   logic        prg_nce_out;
   logic [14:0] prg_a_out;
   logic        prg_r_nw_out;
   logic [7:0]  prg_d_out;
   logic [13:0] chr_a_out;
   logic        chr_r_nw_out;
   logic [7:0]  chr_d_out;
   logic        busy_out;
   logic        done_out;
   logic        err_out;

   cart_loader dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .start_in      (start_in),
      .rom_d_in      (rom_d_in),
      .rom_valid_in  (rom_valid_in),
      .rom_ready_out (rom_ready_out),
      .cfg_out       (cfg_out),
      .cfg_upd_out   (cfg_upd_out),
      .prg_nce_out   (prg_nce_out),
      .prg_a_out     (prg_a_out),
      .prg_r_nw_out  (prg_r_nw_out),
      .prg_d_out     (prg_d_out),
      .chr_a_out     (chr_a_out),
      .chr_r_nw_out  (chr_r_nw_out),
      .chr_d_out     (chr_d_out),
      .busy_out      (busy_out),
      .done_out      (done_out),
      .err_out       (err_out)
   );

   always #5 clk_in = ~clk_in;

   logic [7:0] img [0:IMG_MAX-1];
   int err_cnt = 0;
   int chk_cnt = 0;

   // monitor totals (written only by the monitor)
   int prg_seen = 0, prg_bad = 0, chr_seen = 0, chr_bad = 0, upd_seen = 0, rnw_bad = 0;
   logic [39:0] upd_cfg = 40'h0;
   // scoring window (written only by the stimulus process)
   int base_prg = 0, base_chr = 0, off_prg = 0, off_chr = 0;
   logic [39:0] model_cfg = 40'h0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      chk_cnt++;
      if (got !== exp) begin
         err_cnt++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Strobe scoreboard: k-th strobe of a load must write image byte k of its section at address k
   always @(negedge clk_in) begin
      int k;
      int idx;
      if (prg_nce_out != prg_r_nw_out) rnw_bad++;
      if (!prg_nce_out) begin
         k   = prg_seen - base_prg;
         idx = off_prg + k;
         if (k < 0 || k > 32767 || idx >= IMG_MAX) prg_bad++;
         else if (prg_a_out != k[14:0] || prg_d_out != img[idx]) prg_bad++;
         prg_seen++;
      end
      if (!chr_r_nw_out) begin
         k   = chr_seen - base_chr;
         idx = off_chr + k;
         if (k < 0 || k > 8191 || idx >= IMG_MAX) chr_bad++;
         else if (chr_a_out != {1'b0, k[12:0]} || chr_d_out != img[idx]) chr_bad++;
         chr_seen++;
      end
      if (cfg_upd_out) begin
         upd_seen++;
         upd_cfg = cfg_out;
      end
   end

   task automatic check_reset_vals(input string tag);
      chk({tag, "_ready"}, rom_ready_out, 1'b0);
      chk({tag, "_busy"},  busy_out, 1'b0);
      chk({tag, "_done"},  done_out, 1'b0);
      chk({tag, "_err"},   err_out, 1'b0);
      chk({tag, "_cfg"},   cfg_out, 40'h0);
      chk({tag, "_upd"},   cfg_upd_out, 1'b0);
      chk({tag, "_strb"},  {prg_nce_out, prg_r_nw_out, chr_r_nw_out}, 3'b111);
      chk({tag, "_addr"},  {prg_a_out, chr_a_out}, 29'h0);
      chk({tag, "_data"},  {prg_d_out, chr_d_out}, 16'h0);
   endtask

   task automatic build_img(input logic [7:0] h4, input logic [7:0] h5, input logic [7:0] h6,
                            input bit bad_magic, input bit ramp);
      img[0] = 8'h4E;
      img[1] = bad_magic ? 8'h00 : 8'h45;
      img[2] = 8'h53;
      img[3] = 8'h1A;
      img[4] = h4;
      img[5] = h5;
      img[6] = h6;
      for (int i = 7; i < 16; i++) img[i] = 8'($urandom);
      for (int i = 0; i < IMG_MAX - 16; i++) img[16 + i] = ramp ? i[7:0] : 8'($urandom);
   endtask

   function automatic bit model_ok();
      bit ok;
      ok = (img[4] == 8'd1 || img[4] == 8'd2) && (img[5] == 8'd0 || img[5] == 8'd1);
`ifdef CART_LOADER_MAGIC_CHECK_EN
      ok = ok && img[0] == 8'h4E && img[1] == 8'h45 && img[2] == 8'h53 && img[3] == 8'h1A;
`endif
      return ok;
   endfunction

   task automatic do_start();
      @(negedge clk_in);
      start_in = 1'b1;
      @(negedge clk_in);
      start_in = 1'b0;
      chk("start_ready", {rom_ready_out, busy_out, done_out, err_out}, 4'b1100);
   endtask

   // Offer image bytes 0..n-1; returns on the cycle after the last accepted byte
   task automatic feed(input int n, input bit rnd, output int fed);
      int idx = 0;
      int cyc = 0;
      while (idx < n && cyc < 70000) begin
         @(negedge clk_in);
         rom_valid_in = rnd ? ($urandom_range(0, 7) != 0) : 1'b1;
         rom_d_in     = img[idx];
         if (rom_valid_in && rom_ready_out) idx++;
         cyc++;
      end
      @(negedge clk_in);
      rom_valid_in = 1'b0;
      fed = idx;
   endtask

   task automatic load_and_check(input string nm, input logic [7:0] h4, input logic [7:0] h5,
                                 input logic [7:0] h6, input bit bad, input bit ramp, input bit rnd);
      bit ok;
      int n_tr, n_prg, n_chr, fed, u0, p0, c0;
      logic [39:0] m_cfg;
      build_img(h4, h5, h6, bad, ramp);
      ok    = model_ok();
      m_cfg = {img[8], img[7], img[6], img[5], img[4]};
      n_tr  = img[6][2] ? 512 : 0;
      n_prg = 16384 * int'(img[4]);
      n_chr = (img[5] == 8'd1) ? 8192 : 0;
      base_prg = prg_seen;
      base_chr = chr_seen;
      off_prg  = 16 + n_tr;
      off_chr  = 16 + n_tr + n_prg;
      u0 = upd_seen; p0 = prg_bad; c0 = chr_bad;
      do_start();
      feed(ok ? 16 + n_tr + n_prg + n_chr : 16, rnd, fed);
      chk({nm, "_fed"}, fed, ok ? 16 + n_tr + n_prg + n_chr : 16);
      if (ok) begin
         // final strobe and done/idle appear in the same cycle
         chk({nm, "_final"}, {(!prg_nce_out || !chr_r_nw_out), done_out, busy_out, err_out}, 4'b1100);
         model_cfg = m_cfg;
      end else begin
         chk({nm, "_err"}, {err_out, rom_ready_out, busy_out, done_out}, 4'b1000);
      end
      @(negedge clk_in);
      chk({nm, "_cfg"},     cfg_out, model_cfg);
      chk({nm, "_upd_n"},   upd_seen - u0, ok ? 1 : 0);
      if (ok) chk({nm, "_upd_cfg"}, upd_cfg, m_cfg);
      chk({nm, "_prg_n"},   prg_seen - base_prg, ok ? n_prg : 0);
      chk({nm, "_chr_n"},   chr_seen - base_chr, ok ? n_chr : 0);
      chk({nm, "_prg_bad"}, prg_bad - p0, 0);
      chk({nm, "_chr_bad"}, chr_bad - c0, 0);
   endtask

   initial begin
      int fed, u0, p0;
      // reset state
      repeat (3) @(negedge clk_in);
      check_reset_vals("rst0");
      rst_in = 1'b0;

      // trainer image, reset while PRG byte 1000 is offered
      build_img(8'd1, 8'd0, 8'h04, 1'b0, 1'b0);
      base_prg = prg_seen; off_prg = 16 + 512;
      base_chr = chr_seen; off_chr = 0;
      u0 = upd_seen; p0 = prg_bad;
      do_start();
      feed(16 + 512 + 1000, 1'b1, fed);
      chk("trn_fed", fed, 16 + 512 + 1000);
      chk("trn_busy", {busy_out, rom_ready_out, cfg_out}, {2'b11, img[8], img[7], img[6], img[5], img[4]});
      rst_in = 1'b1; rom_valid_in = 1'b1; rom_d_in = img[16 + 512 + 1000];
      @(negedge clk_in);
      check_reset_vals("rst_mid");
      rst_in = 1'b0; rom_valid_in = 1'b0;
      model_cfg = 40'h0;
      @(negedge clk_in);
      chk("trn_prg_n", prg_seen - base_prg, 1000);
      chk("trn_prg_bad", prg_bad - p0, 0);
      chk("trn_upd_n", upd_seen - u0, 1);
      chk("trn_chr_n", chr_seen - base_chr, 0);

      // full PRG+CHR ramp load with vertical mirroring
      load_and_check("ramp", 8'd1, 8'd1, 8'h01, 1'b0, 1'b1, 1'b0);

      // bad PRG bank count; bytes offered in ERR must be ignored
      load_and_check("bad_h4", 8'd3, 8'd0, 8'h00, 1'b0, 1'b0, 1'b0);
      p0 = prg_seen;
      repeat (4) begin
         @(negedge clk_in);
         rom_valid_in = 1'b1;
         chk("err_hold", {err_out, rom_ready_out, busy_out}, 3'b100);
      end
      rom_valid_in = 1'b0;
      @(negedge clk_in);
      chk("err_no_strb", prg_seen - p0, 0);

      // bad signature byte 1, two PRG banks, no CHR, random valid gaps
      load_and_check("magic", 8'd2, 8'd0, 8'($urandom) & 8'hFB, 1'b1, 1'b0, 1'b1);
`ifdef CART_LOADER_MAGIC_CHECK_EN
      load_and_check("prg2", 8'd2, 8'd0, 8'($urandom) & 8'hFB, 1'b0, 1'b0, 1'b1);
`endif

      chk("rnw_coherent", rnw_bad, 0);
      $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/cart_loader.md
# cart_loader

Writes an iNES cartridge image into the cartridge emulator's memories. Consumes the image as a byte stream with a valid/ready handshake and parses the 16-byte header into the 40-bit mapper config with its update pulse. It then drives the cartridge's PRG-ROM and CHR-ROM write ports, acting as the initiator on those ports, to fill the PRG banks and the CHR pattern table. It sits between the debug/host byte link and the cartridge. While `busy_out` is high, an external mux gives the loader the cartridge ports instead of the CPU/PPU.

## Interface
Parameters: none.

Clocking and reset: one clock (`clk_in`). Reset is synchronous and active-high (`rst_in`).

- `clk_in` in 1: system clock
- `rst_in` in 1: synchronous active-high reset
- `start_in` in 1: begin a load; honoured only in IDLE/DONE/ERR
- `rom_d_in` in 8: image byte
- `rom_valid_in` in 1: `rom_d_in` valid
- `rom_ready_out` out 1: loader accepts a byte this cycle (a byte transfers when valid && ready)
- `cfg_out` out 40: {hdr[8], hdr[7], hdr[6], hdr[5], hdr[4]}; bit 16 = vertical mirroring
- `cfg_upd_out` out 1: one-cycle pulse when `cfg_out` is updated
- `prg_nce_out` out 1: PRG chip enable, active low
- `prg_a_out` out 15: PRG address
- `prg_r_nw_out` out 1: PRG read/write select; 0 = write
- `prg_d_out` out 8: PRG write data
- `chr_a_out` out 14: CHR address; bit 13 always 0
- `chr_r_nw_out` out 1: CHR read/write select; 0 = write
- `chr_d_out` out 8: CHR write data
- `busy_out` out 1: load in progress
- `done_out` out 1: load completed successfully (level)
- `err_out` out 1: header rejected (level)

## Operation
- States: IDLE, HDR, TRAIN, PRG, CHR, DONE, ERR.
- `rom_ready_out` is 1 only in HDR, TRAIN, PRG and CHR. It depends on state only, not on `rom_valid_in`.
- `busy_out` = state in {HDR, TRAIN, PRG, CHR}.
- IDLE/DONE/ERR + `start_in` → HDR. This clears the byte counter, `done_out` and `err_out`.
- HDR: accepted bytes 0–15 are counted. Bytes 4–8 are latched into a shadow config; bytes 9–15 are discarded. On acceptance of byte 15, the header is validated:
  - Reject if hdr[4] ∉ {1,2}.
  - Reject if hdr[5] ∉ {0,1}.
  - Reject on magic mismatch (see Configuration).
  - Reject → ERR. `cfg_out` is unchanged and there is no update pulse.
  - Accept → copy the shadow config to `cfg_out`, pulse `cfg_upd_out`, then go to TRAIN if hdr[6] bit 2 is set, else PRG.
- TRAIN: 512 bytes are accepted and discarded, then → PRG.
- PRG: N = 16384·hdr[4] bytes are written to addresses 0..N−1 in stream order, then → CHR if hdr[5] = 1, else DONE.
- CHR: 8192 bytes are written to CHR addresses 0x0000–0x1FFF, then → DONE.
- Byte counter width is 15 bits. Each section's counter is cleared on entry. The transition happens on acceptance of the section's last byte; there is no wrap.
- DONE: `done_out` = 1. ERR: `err_out` = 1. Both hold until `start_in` or reset.
- Write strobe: each byte accepted in PRG registers address and data, and the next cycle drives `prg_nce_out` = 0 and `prg_r_nw_out` = 0 for exactly one cycle. CHR is identical, using `chr_r_nw_out` = 0. All other cycles: `prg_nce_out` = 1, `prg_r_nw_out` = 1, `chr_r_nw_out` = 1.
- `start_in` while busy is ignored. `rom_valid_in` outside the ready states is ignored; no byte is consumed.
- `rst_in` mid-load aborts immediately: state → IDLE and any pending strobe is dropped. The partially written memory is left as is.

## Timing
- Reset values:
  - state IDLE
  - `rom_ready_out` 0, `busy_out` 0, `done_out` 0, `err_out` 0
  - `cfg_out` 40'h0, `cfg_upd_out` 0
  - `prg_nce_out` 1, `prg_r_nw_out` 1, `chr_r_nw_out` 1
  - all address and data outputs 0
- `start_in` at cycle t → `rom_ready_out` = 1 at t+1.
- Byte accepted at t → write strobe at t+1. Sustained throughput is 1 byte per cycle; back-to-back strobes are legal.
- Header byte 15 accepted at t → `cfg_out` valid and `cfg_upd_out` = 1 at t+1. At t+1 the state is TRAIN/PRG/ERR, with ready = 1 in TRAIN/PRG.
- Last data byte accepted at t → final strobe at t+1, `done_out` = 1 and `busy_out` = 0 at t+1.
- `cfg_upd_out` is high for exactly one cycle per successful header.

## Configuration
- `CART_LOADER_MAGIC_CHECK_EN` defined: hdr[0..3] must equal 8'h4E, 8'h45, 8'h53, 8'h1A. A mismatch flag is set at the failing byte (sticky) and evaluated at byte 15 → ERR.
- Undefined: bytes 0–3 are discarded unchecked.

## Test plan
- Valid header with PRG=1, CHR=1, flags6=0x01, then 24576 ramp bytes (i & 0xFF):
  - `cfg_upd_out` pulses once with `cfg_out` bit 16 = 1.
  - 16384 PRG strobes with address 0x0000..0x3FFF carrying data = addr & 0xFF.
  - 8192 CHR strobes with address 0x0000..0x1FFF.
  - `done_out` = 1.
- PRG=2, CHR=0, `rom_valid_in` toggled randomly → 32768 PRG strobes with address up to 0x7FFF, no CHR strobes, `done_out` = 1 the cycle after the final strobe.
- flags6=0x04 (trainer) → the first 512 post-header bytes produce no strobe; the 513th byte lands at PRG 0x0000.
- hdr[4]=3 → `err_out` = 1 after byte 15, no `cfg_upd_out`, `cfg_out` keeps its prior value, `rom_ready_out` = 0. A later `start_in` then clears `err_out`.
- Magic byte 1 = 0x00 with macro defined → ERR. Same image without the macro → normal load.
- `rst_in` asserted mid-PRG at byte 1000 → the next cycle shows IDLE, all reset values and no strobe. A following `start_in` plus a valid image completes normally.
